// File: rtl/uart_tx_arbiter_of_verifla_pkg.sv
// uart_tx_arbiter_of_verifla_pkg: arbiter state encodings, requester indices and default limits
package uart_tx_arbiter_of_verifla_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_IDLE, NEXT} arb_state_e;
  localparam int GAP_LIMIT_DEF = 255;
  localparam int GAP_BITS_DEF = 8;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  function automatic logic [1:0] onehot(input logic idx);
    return idx == REQ1 ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_of_verifla_if.sv
// uart_tx_arbiter_of_verifla_if: requester byte streams plus UART transmit handshake
interface uart_tx_arbiter_of_verifla_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ack;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ack;
  logic       xmit_doneH;
  logic       xmitH;
  logic [7:0] xmit_dataH;
  logic [1:0] grant;
  logic       gap_error;
  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, xmit_doneH,
    input  req0_ack, req1_ack, xmitH, xmit_dataH, grant, gap_error
  );
  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, xmit_doneH,
    output req0_ack, req1_ack, xmitH, xmit_dataH, grant, gap_error
  );
endinterface

// File: rtl/uart_tx_arbiter_of_verifla.sv
// uart_tx_arbiter_of_verifla: packet-level round-robin sharing of one UART transmitter
// between the capture dump (req 0) and the status responder (req 1).
module uart_tx_arbiter_of_verifla
  import uart_tx_arbiter_of_verifla_pkg::*;
#(
  parameter int GAP_LIMIT = GAP_LIMIT_DEF,
  parameter int GAP_BITS  = GAP_BITS_DEF
) (
  input logic clk,
  input logic rst_l,
  uart_tx_arbiter_of_verifla_if.slave bus
);
  localparam logic [GAP_BITS-1:0] CNT_MAX = GAP_BITS'(GAP_LIMIT - 1);
  arb_state_e state_q;
  logic [GAP_BITS-1:0] cnt_q, cnt_d;
  logic owner_q, last_winner_q, last_q, xmit_q, gap_err_q;
  logic [7:0] data_q;
  logic [1:0] ack_q, grant_q, vld;
  logic win_d, own_vld;
  assign vld     = {bus.req1_valid, bus.req0_valid};
  assign win_d   = &vld ? ~last_winner_q : vld[REQ1];
  assign own_vld = owner_q ? bus.req1_valid : bus.req0_valid;
  assign cnt_d   = cnt_q + 1'b1;
  // The ack cycle is skipped in IDLE/NEXT: the requester still shows the acked byte then.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= REQ0;
      last_winner_q <= REQ1;
      last_q        <= 1'b0;
      xmit_q        <= 1'b0;
      gap_err_q     <= 1'b0;
      data_q        <= 8'h00;
      ack_q         <= 2'b00;
      grant_q       <= 2'b00;
    end else begin
      xmit_q <= 1'b0;
      ack_q  <= 2'b00;
      unique case (state_q)
        IDLE: if (bus.xmit_doneH && |vld && !(|ack_q)) begin
          owner_q       <= win_d;
          last_winner_q <= win_d;
          grant_q       <= onehot(win_d);
          data_q        <= win_d ? bus.req1_data : bus.req0_data;
          last_q        <= win_d ? bus.req1_last : bus.req0_last;
          xmit_q        <= 1'b1;
          cnt_q         <= '0;
          state_q       <= START;
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!bus.xmit_doneH) begin
          cnt_q   <= '0;
          state_q <= WAIT_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          xmit_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= START;
        end else cnt_q <= cnt_d;
        WAIT_IDLE: if (bus.xmit_doneH) begin
          ack_q   <= grant_q;
          cnt_q   <= '0;
          grant_q <= last_q ? 2'b00 : grant_q;
          state_q <= last_q ? IDLE : NEXT;
        end
        NEXT: if (!(|ack_q)) begin
          if (own_vld) begin
            data_q  <= owner_q ? bus.req1_data : bus.req0_data;
            last_q  <= owner_q ? bus.req1_last : bus.req0_last;
            xmit_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= START;
          end else if (cnt_q == CNT_MAX) begin
            gap_err_q <= 1'b1;
            grant_q   <= 2'b00;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else cnt_q <= cnt_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.xmitH      = xmit_q;
  assign bus.xmit_dataH = data_q;
  assign bus.grant      = grant_q;
  assign bus.gap_error  = gap_err_q;
  assign bus.req0_ack   = ack_q[0];
  assign bus.req1_ack   = ack_q[1];
endmodule

// File: tb/tb_uart_tx_arbiter_of_verifla.sv
// tb_uart_tx_arbiter_of_verifla: directed packets against a UART model, scoreboard on xmitH/ack
module tb_uart_tx_arbiter_of_verifla;
  localparam int GL = 255;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int n_vec = 0, n_err = 0, cyc = 0;
  bit ignore_next = 0;
  logic [9:0] exp_x[$];
  logic [1:0] exp_a[$];
  int x_times[$];
  uart_tx_arbiter_of_verifla_if bus ();
  uart_tx_arbiter_of_verifla #(.GAP_LIMIT(GL), .GAP_BITS(8)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // UART model: busy 2 cycles after xmitH, idle again 20 cycles later
  initial begin
    bus.xmit_doneH = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.xmitH) begin
        if (ignore_next) ignore_next = 0;
        else begin
          repeat (2) @(posedge clk);
          #1 bus.xmit_doneH = 1'b0;
          repeat (20) @(posedge clk);
          #1 bus.xmit_doneH = 1'b1;
        end
      end
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT starts a byte or acks one
  always @(negedge clk) begin
    cyc++;
    if (bus.xmitH) begin
      x_times.push_back(cyc);
      if (exp_x.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL xmit_unexpected: got grant=%b data=%h, none required", bus.grant, bus.xmit_dataH);
      end else chk("xmit_grant_data", {22'd0, bus.grant, bus.xmit_dataH}, {22'd0, exp_x.pop_front()});
    end
    if (bus.req0_ack || bus.req1_ack) begin
      if (exp_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL ack_unexpected: got ack=%b, none required", {bus.req1_ack, bus.req0_ack});
      end else chk("ack_owner", {30'd0, bus.req1_ack, bus.req0_ack}, {30'd0, exp_a.pop_front()});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end
  endtask

  task automatic wait_ack(input int r, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (r == 0 ? bus.req0_ack : bus.req1_ack) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic send(input int r, input logic [7:0] b[3], input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      set_req(r, 1'b1, b[i], i == n - 1);
      wait_ack(r, ok);
      if (!ok) begin
        fail_to("ack_wait");
        break;
      end
    end
    set_req(r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_x.size() == 0 && exp_a.size() == 0 && bus.grant == 2'b00 && bus.xmit_doneH) break;
    end
    repeat (3) @(negedge clk);
    chk({name, "_drain"}, exp_x.size() + exp_a.size(), 0);
    chk({name, "_grant_idle"}, {30'd0, bus.grant}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int k;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_xmitH", {31'd0, bus.xmitH}, 0);
    chk("rst_data", {24'd0, bus.xmit_dataH}, 0);
    chk("rst_grant", {30'd0, bus.grant}, 0);
    chk("rst_ack", {30'd0, bus.req1_ack, bus.req0_ack}, 0);
    chk("rst_gap", {31'd0, bus.gap_error}, 0);
    rst_l = 1'b1;
    @(negedge clk);

    // 1: req0 alone, 3-byte packet
    exp_x = '{10'h1A1, 10'h1A2, 10'h1A3};
    exp_a = '{2'b01, 2'b01, 2'b01};
    send(0, '{8'hA1, 8'hA2, 8'hA3}, 3);
    drain("t1");

    // 2: tie after reset -> req0 first; later tie with last_winner=0 -> req1 first
    do_reset();
    exp_x = '{10'h1B1, 10'h1B2, 10'h2C1, 10'h2C2};
    exp_a = '{2'b01, 2'b01, 2'b10, 2'b10};
    fork
      send(0, '{8'hB1, 8'hB2, 8'h00}, 2);
      send(1, '{8'hC1, 8'hC2, 8'h00}, 2);
    join
    drain("t2a");
    exp_x = '{10'h1B3};
    exp_a = '{2'b01};
    send(0, '{8'hB3, 8'h00, 8'h00}, 1);
    drain("t2b");
    exp_x = '{10'h2C3, 10'h1B4};
    exp_a = '{2'b10, 2'b01};
    fork
      send(0, '{8'hB4, 8'h00, 8'h00}, 1);
      send(1, '{8'hC3, 8'h00, 8'h00}, 1);
    join
    drain("t2c");

    // 3: req1 arrives mid-packet and must wait for req0's last ack
    exp_x = '{10'h1A4, 10'h1A5, 10'h1A6, 10'h2C4};
    exp_a = '{2'b01, 2'b01, 2'b01, 2'b10};
    fork
      send(0, '{8'hA4, 8'hA5, 8'hA6}, 3);
      begin
        repeat (30) @(negedge clk);
        send(1, '{8'hC4, 8'h00, 8'h00}, 1);
      end
    join
    drain("t3");

    // 4: req0 stalls mid-packet -> forced release, then req1 serviced
    exp_x = '{10'h1D0, 10'h2E0};
    exp_a = '{2'b01, 2'b10};
    fork
      begin
        set_req(0, 1'b1, 8'hD0, 1'b0);
        wait_ack(0, ok);
        set_req(0, 1'b0, 8'h00, 1'b0);
        if (!ok) fail_to("t4_ack");
        k = 0;
        for (int i = 1; i <= 400; i++) begin
          @(negedge clk);
          if (i == GL - 10) chk("t4_gap_early", {31'd0, bus.gap_error}, 0);
          if (bus.gap_error) begin
            k = i;
            break;
          end
        end
        chk("t4_gap_timing", {31'd0, k >= GL && k <= GL + 2}, 1);
        chk("t4_grant_released", {30'd0, bus.grant}, 0);
      end
      begin
        repeat (120) @(negedge clk);
        send(1, '{8'hE0, 8'h00, 8'h00}, 1);
      end
    join
    drain("t4");
    chk("t4_gap_sticky", {31'd0, bus.gap_error}, 1);

    // 5: UART drops the first start -> same byte re-sent after GAP_LIMIT, no error
    do_reset();
    chk("t5_gap_cleared", {31'd0, bus.gap_error}, 0);
    x_times.delete();
    ignore_next = 1;
    exp_x = '{10'h1F0, 10'h1F0};
    exp_a = '{2'b01};
    send(0, '{8'hF0, 8'h00, 8'h00}, 1);
    drain("t5");
    if (x_times.size() == 2) chk("t5_retry_gap", {31'd0, (x_times[1] - x_times[0]) >= GL && (x_times[1] - x_times[0]) <= GL + 2}, 1);
    else chk("t5_retry_count", x_times.size(), 2);
    chk("t5_no_gap_error", {31'd0, bus.gap_error}, 0);

    // 6: reset asserted while the byte is on the wire
    exp_x = '{10'h177};
    set_req(0, 1'b1, 8'h77, 1'b1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.xmit_doneH && bus.grant != 2'b00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_to("t6_busy");
    repeat (3) @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("t6_xmitH", {31'd0, bus.xmitH}, 0);
    chk("t6_data", {24'd0, bus.xmit_dataH}, 0);
    chk("t6_grant", {30'd0, bus.grant}, 0);
    chk("t6_ack", {30'd0, bus.req1_ack, bus.req0_ack}, 0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    repeat (30) @(negedge clk);
    rst_l = 1'b1;
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
